// File: rtl/pc_sequencer_if.sv
// Bus bundle between the PC sequencer and its surrounding datapath:
// request/acknowledge handshakes, interrupt inputs, memory strobes,
// stack-pointer strobes and PC control strobes.
interface pc_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    // Requests and handshakes
    logic                  fetch_req;
    logic                  fetch_vld;
    logic [DATA_WIDTH-1:0] fetch_data;
    logic                  jmp_req;
    logic [DATA_WIDTH-1:0] jmp_l;
    logic [DATA_WIDTH-1:0] jmp_h;
    logic                  jmp_ack;

    // Interrupts
    logic                  nmi;
    logic                  irq;
    logic                  irq_mask;

    // Status and memory
    logic                  busy;
    logic [DATA_WIDTH-1:0] db_i;
    logic                  mem_rd;
    logic                  mem_wr;

    // Vector addressing and stack pointer
    logic                  vec_abl_en;
    logic [DATA_WIDTH-1:0] vec_addr_l;
    logic                  sp_abl;
    logic                  sp_dec;

    // PC control strobes and load target
    logic                  pcl_abl;
    logic                  pch_abh;
    logic                  pcl_db;
    logic                  pch_db;
    logic                  abl_pcl;
    logic                  abh_pch;
    logic                  pci;
    logic [DATA_WIDTH-1:0] abli;
    logic [DATA_WIDTH-1:0] abhi;

    // Sequencer side
    modport slave (
        input  fetch_req, jmp_req, jmp_l, jmp_h, nmi, irq, irq_mask, db_i,
        output fetch_vld, fetch_data, jmp_ack, busy, mem_rd, mem_wr,
               vec_abl_en, vec_addr_l, sp_abl, sp_dec,
               pcl_abl, pch_abh, pcl_db, pch_db, abl_pcl, abh_pch, pci,
               abli, abhi
    );

    // Datapath / requester side
    modport master (
        output fetch_req, jmp_req, jmp_l, jmp_h, nmi, irq, irq_mask, db_i,
        input  fetch_vld, fetch_data, jmp_ack, busy, mem_rd, mem_wr,
               vec_abl_en, vec_addr_l, sp_abl, sp_dec,
               pcl_abl, pch_abh, pcl_db, pch_db, abl_pcl, abh_pch, pci,
               abli, abhi
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: reset-vector load, byte fetch with PC
// increment, absolute jump, and NMI/IRQ entry (push PCH, PCL, then load
// the vector). All outputs are decoded from the current state (db_i is
// passed through in the states that consume read data).
module pc_sequencer #(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] VEC_H      = 8'hFF,
    parameter logic [DATA_WIDTH-1:0] NMI_VEC_L  = 8'hFA,
    parameter logic [DATA_WIDTH-1:0] RST_VEC_L  = 8'hFC,
    parameter logic [DATA_WIDTH-1:0] IRQ_VEC_L  = 8'hFE
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);

    typedef enum logic [3:0] {
        S_RST,
        S_VEC_A,
        S_VEC_B,
        S_VEC_LD,
        S_IDLE,
        S_PUSH_H,
        S_PUSH_L,
        S_JUMP,
        S_FETCH_A,
        S_FETCH_D
    } state_t;

    typedef enum logic [1:0] {
        SEL_RST,
        SEL_NMI,
        SEL_IRQ
    } vec_sel_t;

    // The vector page shares the bus with the stack page; they must differ.
    if (VEC_H == DATA_WIDTH'(1)) begin : g_vec_page_check
        $error("pc_sequencer: vector page collides with the stack page");
    end

    state_t                state, state_d;
    vec_sel_t              sel, sel_d;
    logic                  nmi_q;
    logic                  nmi_pend;
    logic                  nmi_edge;
    logic                  nmi_any;
    logic                  nmi_take;
    logic [DATA_WIDTH-1:0] tmp_l;
    logic [DATA_WIDTH-1:0] sel_l;

    // A fresh edge counts in the same IDLE cycle, so an NMI arriving
    // alongside an IRQ wins; that edge is then consumed rather than latched.
    assign nmi_edge = bus.nmi & ~nmi_q;
    assign nmi_any  = nmi_pend | nmi_edge;

    // State register; reset aborts any sequence immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RST;
        end else begin
            state <= state_d;
        end
    end

    // NMI edge tracking, vector select and low-byte holding register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nmi_q    <= 1'b0;
            nmi_pend <= 1'b0;
            tmp_l    <= '0;
            sel      <= SEL_RST;
        end else begin
            nmi_q    <= bus.nmi;
            nmi_pend <= nmi_take ? 1'b0 : nmi_any;
            sel      <= sel_d;
            if (state == S_VEC_B) begin
                tmp_l <= bus.db_i;
            end
        end
    end

    // Low byte of the selected vector.
    always_comb begin
        sel_l = RST_VEC_L;
        case (sel)
            SEL_NMI: sel_l = NMI_VEC_L;
            SEL_IRQ: sel_l = IRQ_VEC_L;
            default: sel_l = RST_VEC_L;
        endcase
    end

    // Next-state decision, including the IDLE arbitration.
    always_comb begin
        state_d  = state;
        sel_d    = sel;
        nmi_take = 1'b0;
        case (state)
            S_RST: begin
                sel_d   = SEL_RST;
                state_d = S_VEC_A;
            end
            S_VEC_A:  state_d = S_VEC_B;
            S_VEC_B:  state_d = S_VEC_LD;
            S_VEC_LD: state_d = S_IDLE;
            S_IDLE: begin
                if (nmi_any) begin
                    nmi_take = 1'b1;
                    sel_d    = SEL_NMI;
                    state_d  = S_PUSH_H;
                end else if (bus.irq && !bus.irq_mask) begin
                    sel_d   = SEL_IRQ;
                    state_d = S_PUSH_H;
                end else if (bus.jmp_req) begin
                    state_d = S_JUMP;
                end else if (bus.fetch_req) begin
                    state_d = S_FETCH_A;
                end
            end
            S_PUSH_H:  state_d = S_PUSH_L;
            S_PUSH_L:  state_d = S_VEC_A;
            S_JUMP:    state_d = S_IDLE;
            S_FETCH_A: state_d = S_FETCH_D;
            S_FETCH_D: state_d = S_IDLE;
            default:   state_d = S_RST;
        endcase
    end

    // State-decoded strobes; everything idles at zero unless asserted here.
    always_comb begin
        bus.busy       = (state != S_IDLE);
        bus.fetch_vld  = 1'b0;
        bus.fetch_data = '0;
        bus.jmp_ack    = 1'b0;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.vec_abl_en = 1'b0;
        bus.vec_addr_l = '0;
        bus.sp_abl     = 1'b0;
        bus.sp_dec     = 1'b0;
        bus.pcl_abl    = 1'b0;
        bus.pch_abh    = 1'b0;
        bus.pcl_db     = 1'b0;
        bus.pch_db     = 1'b0;
        bus.abl_pcl    = 1'b0;
        bus.abh_pch    = 1'b0;
        bus.pci        = 1'b0;
        bus.abli       = '0;
        bus.abhi       = '0;
        case (state)
            S_VEC_A: begin
                bus.vec_abl_en = 1'b1;
                bus.mem_rd     = 1'b1;
                bus.vec_addr_l = sel_l;
            end
            S_VEC_B: begin
                bus.vec_abl_en = 1'b1;
                bus.mem_rd     = 1'b1;
                bus.vec_addr_l = sel_l + DATA_WIDTH'(1);
            end
            S_VEC_LD: begin
                bus.abli    = tmp_l;
                bus.abhi    = bus.db_i;
                bus.abl_pcl = 1'b1;
                bus.abh_pch = 1'b1;
            end
            S_PUSH_H: begin
                bus.sp_abl = 1'b1;
                bus.mem_wr = 1'b1;
                bus.pch_db = 1'b1;
                bus.sp_dec = 1'b1;
            end
            S_PUSH_L: begin
                bus.sp_abl = 1'b1;
                bus.mem_wr = 1'b1;
                bus.pcl_db = 1'b1;
                bus.sp_dec = 1'b1;
            end
            S_JUMP: begin
                bus.abli    = bus.jmp_l;
                bus.abhi    = bus.jmp_h;
                bus.abl_pcl = 1'b1;
                bus.abh_pch = 1'b1;
                bus.jmp_ack = 1'b1;
            end
            S_FETCH_A: begin
                bus.pcl_abl = 1'b1;
                bus.pch_abh = 1'b1;
                bus.mem_rd  = 1'b1;
            end
            S_FETCH_D: begin
                bus.pci        = 1'b1;
                bus.fetch_vld  = 1'b1;
                bus.fetch_data = bus.db_i;
            end
            default: ;
        endcase
    end

endmodule
